// File: rtl/alu_mdu.sv
// alu_mdu: registered MIPS-style ALU with an iterative unsigned multiply/divide
// unit and HI/LO registers, for use in the EX stage.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid / o_ready   request handshake; transfer when both are high
//   i_op1, i_op2        operands A and B, latched at accept
//   i_control           opcode, latched at accept
//   o_valid             one-cycle pulse when o_result/o_zf are updated
//   o_result, o_zf      registered result and its zero flag
//   o_hi, o_lo          HI/LO registers
module alu_mdu #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_op1,
  input  logic [WIDTH-1:0]  i_op2,
  input  logic [CTRL_W-1:0] i_control,
  output logic              o_valid,
  output logic [WIDTH-1:0]  o_result,
  output logic              o_zf,
  output logic [WIDTH-1:0]  o_hi,
  output logic [WIDTH-1:0]  o_lo
);

  localparam int CNT_W = $clog2(WIDTH);

  localparam logic [CTRL_W-1:0] OP_AND  = CTRL_W'(4'b0000);
  localparam logic [CTRL_W-1:0] OP_OR   = CTRL_W'(4'b0001);
  localparam logic [CTRL_W-1:0] OP_ADD  = CTRL_W'(4'b0010);
  localparam logic [CTRL_W-1:0] OP_SUB  = CTRL_W'(4'b0110);
  localparam logic [CTRL_W-1:0] OP_SLT  = CTRL_W'(4'b0111);
  localparam logic [CTRL_W-1:0] OP_NOR  = CTRL_W'(4'b1100);
  localparam logic [CTRL_W-1:0] OP_MULT = CTRL_W'(4'b1000);
  localparam logic [CTRL_W-1:0] OP_DIV  = CTRL_W'(4'b1001);
  localparam logic [CTRL_W-1:0] OP_MFHI = CTRL_W'(4'b1010);
  localparam logic [CTRL_W-1:0] OP_MFLO = CTRL_W'(4'b1011);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_trial;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic               last_iter;

  assign o_ready   = (state == IDLE);
  assign last_iter = (cnt == CNT_W'(WIDTH - 1));

  always_comb begin
    alu_res = '0;
    case (i_control)
      OP_AND:  alu_res = i_op1 & i_op2;
      OP_OR:   alu_res = i_op1 | i_op2;
      OP_ADD:  alu_res = i_op1 + i_op2;
      OP_SUB:  alu_res = i_op1 - i_op2;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(i_op1) < $signed(i_op2))};
      OP_NOR:  alu_res = ~(i_op1 | i_op2);
      OP_MFHI: alu_res = o_hi;
      OP_MFLO: alu_res = o_lo;
      OP_DIV:  alu_res = '1;  // only reached with B == 0
      default: alu_res = '0;
    endcase
  end

  // Multiply: acc = {partial product, remaining multiplier bits}; add B to the
  // upper half when the current LSB is set, then shift right with the carry.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b_q} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end

  // Divide: acc = {remainder, dividend/quotient}; shift the next dividend bit
  // into the remainder and subtract B, restoring when the result goes negative.
  always_comb begin
    div_trial = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_trial - {1'b0, b_q};
    if (div_diff[WIDTH])
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      b_q      <= '0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_zf     <= 1'b1;
      o_hi     <= '0;
      o_lo     <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_valid) begin
            if (i_control == OP_MULT || (i_control == OP_DIV && i_op2 != '0)) begin
              acc   <= {{WIDTH{1'b0}}, i_op1};
              b_q   <= i_op2;
              cnt   <= '0;
              state <= (i_control == OP_MULT) ? MUL : DIV;
            end else begin
              o_result <= alu_res;
              o_zf     <= (alu_res == '0);
              o_valid  <= 1'b1;
              if (i_control == OP_DIV) begin
                o_lo <= '1;
                o_hi <= i_op1;
              end
            end
          end
        end
        MUL, DIV: begin
          acc <= (state == MUL) ? mul_next : div_next;
          cnt <= cnt + CNT_W'(1);
          if (last_iter) begin
            cnt      <= '0;
            state    <= IDLE;
            o_valid  <= 1'b1;
            if (state == MUL) begin
              o_hi     <= mul_next[2*WIDTH-1:WIDTH];
              o_lo     <= mul_next[WIDTH-1:0];
              o_result <= mul_next[WIDTH-1:0];
              o_zf     <= (mul_next[WIDTH-1:0] == '0);
            end else begin
              o_hi     <= div_next[2*WIDTH-1:WIDTH];
              o_lo     <= div_next[WIDTH-1:0];
              o_result <= div_next[WIDTH-1:0];
              o_zf     <= (div_next[WIDTH-1:0] == '0);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mdu.sv
module tb_alu_mdu;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready;
  logic [W-1:0]  op1 = '0;
  logic [W-1:0]  op2 = '0;
  logic [3:0]    ctrl = '0;
  logic          valid_out;
  logic [W-1:0]  result;
  logic          zf;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;

  int checks = 0;
  int errors = 0;

  // reference HI/LO
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  alu_mdu #(.WIDTH(W), .CTRL_W(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid_in), .o_ready(ready),
    .i_op1(op1), .i_op2(op2), .i_control(ctrl), .o_valid(valid_out),
    .o_result(result), .o_zf(zf), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model from the opcode table; updates m_hi/m_lo.
  function automatic logic [W-1:0] model(input logic [3:0] c, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    logic [63:0] p;
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return W'(64'(a) + 64'(b));
      4'b0110: return W'(64'(a) - 64'(b));
      4'b0111: return (int'(a) < int'(b)) ? 1 : 0;
      4'b1100: return ~(a | b);
      4'b1000: begin
        p = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
        return m_lo;
      end
      4'b1001: begin
        if (b == 0) begin
          m_lo = '1;
          m_hi = a;
        end else begin
          m_lo = a / b;
          m_hi = a % b;
        end
        return m_lo;
      end
      4'b1010: return m_hi;
      4'b1011: return m_lo;
      default: return '0;
    endcase
  endfunction

  function automatic int exp_lat(input logic [3:0] c, input logic [W-1:0] b);
    if (c == 4'b1000 || (c == 4'b1001 && b != 0)) return W + 1;
    return 1;
  endfunction

  // Called at a negedge; returns at the negedge where o_valid is seen.
  task automatic issue(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    logic [W-1:0] er;
    int n;
    int busy;
    int lat;
    lat = exp_lat(c, b);
    er = model(c, a, b);
    chk({tag, " ready before accept"}, 64'(ready), 64'd1);
    ctrl = c; op1 = a; op2 = b; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    op1 = ~a; op2 = ~b;  // operand changes after accept must not matter
    n = 0; busy = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (valid_out) break;
      if (!ready) busy++;
    end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk({tag, " ready-low cycles"}, 64'(busy), 64'(lat - 1));
    chk({tag, " result"}, 64'(result), 64'(er));
    chk({tag, " zf"}, 64'(zf), 64'(er == 0));
    chk({tag, " hi"}, 64'(hi), 64'(m_hi));
    chk({tag, " lo"}, 64'(lo), 64'(m_lo));
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    chk({tag, " valid single pulse"}, 64'(valid_out), 64'd0);
  endtask

  initial begin
    logic [3:0]   codes [10];
    logic [3:0]   c;
    logic [W-1:0] a, b, er;
    int pulses;
    codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100,
              4'b1000, 4'b1001, 4'b1010, 4'b1011};

    // reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset ready", 64'(ready), 64'd1);
    chk("reset valid", 64'(valid_out), 64'd0);
    chk("reset result", 64'(result), 64'd0);
    chk("reset zf", 64'(zf), 64'd1);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    // single-cycle ops with A=B=1, back-to-back
    issue("and1", 4'b0000, 1, 1);
    issue("or1",  4'b0001, 1, 1);
    issue("add1", 4'b0010, 1, 1);
    issue("sub1", 4'b0110, 1, 1);
    issue("slt1", 4'b0111, 1, 1);
    issue("nor1", 4'b1100, 1, 1);
    idle_cycle("nor1");

    issue("slt neg", 4'b0111, 32'hFFFFFFFF, 1);
    issue("slt pos", 4'b0111, 1, 32'hFFFFFFFF);
    issue("add wrap", 4'b0010, 32'hFFFFFFFF, 1);
    issue("undef", 4'b0011, 32'h1234, 32'h5678);

    // MULTU, then MFHI accepted in the o_valid cycle
    issue("multu max", 4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
    issue("mfhi", 4'b1010, 0, 0);
    issue("mflo", 4'b1011, 0, 0);
    idle_cycle("mflo");

    issue("divu 100/7", 4'b1001, 100, 7);
    idle_cycle("divu");
    issue("divu by 0", 4'b1001, 5, 0);
    issue("undef keeps hilo", 4'b1111, 1, 2);

    // ADD held high while MDU is busy: accepted exactly once, after o_ready
    er = model(4'b1000, 32'h00012345, 32'h00000100);
    ctrl = 4'b1000; op1 = 32'h00012345; op2 = 32'h00000100; valid_in = 1'b1;
    @(posedge clk);
    #1 ctrl = 4'b0010; op1 = 32'd40; op2 = 32'd2;
    pulses = 0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (valid_out) begin
        pulses++;
        if (pulses == 1) begin
          chk("held mul cycle", 64'(n), 64'(W + 1));
          chk("held mul result", 64'(result), 64'(er));
        end else if (pulses == 2) begin
          chk("held add cycle", 64'(n), 64'(W + 2));
          chk("held add result", 64'(result), 64'd42);
          valid_in = 1'b0;
        end
      end
    end
    valid_in = 1'b0;
    chk("held pulses", 64'(pulses), 64'd2);
    chk("held hi", 64'(hi), 64'(m_hi));

    // reset 10 cycles into a DIVU
    @(negedge clk);
    ctrl = 4'b1001; op1 = 32'd1000; op2 = 32'd3; valid_in = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    chk("abort ready", 64'(ready), 64'd1);
    chk("abort valid", 64'(valid_out), 64'd0);
    chk("abort result", 64'(result), 64'd0);
    chk("abort zf", 64'(zf), 64'd1);
    chk("abort hi", 64'(hi), 64'd0);
    chk("abort lo", 64'(lo), 64'd0);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_out) pulses++;
    end
    chk("abort no late valid", 64'(pulses), 64'd0);
    chk("abort lo after", 64'(lo), 64'd0);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) c = 4'($urandom_range(13, 15));
      else c = codes[$urandom_range(0, 9)];
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom >> $urandom_range(0, 31));
      issue($sformatf("rand%0d op%b", i, c), c, a, b);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
